data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_array.sv | 30 +++
 rtl/data_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller: access size
// encodings, controller FSM states and the load lane-extract/extend function.
package dmem_pkg;

   // Widest data word the extract helper can handle; callers cast to DATA_W.
   localparam int DMEM_MAX_W = 512;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RESP
   } state_e;

   // Pull the addressed byte/half out of a full word and sign/zero extend it.
   // Word accesses are always aligned, so the word is returned untouched.
   function automatic logic [DMEM_MAX_W-1:0] lane_extract(
      input logic [DMEM_MAX_W-1:0] data,
      input logic [5:0]            off,
      input size_e                 size,
      input logic                  is_unsigned
   );
      logic [DMEM_MAX_W-1:0] shifted;
      logic [DMEM_MAX_W-1:0] res;
      shifted = data >> {off, 3'b000};
      case (size)
         SZ_BYTE: res = is_unsigned ? {{(DMEM_MAX_W-8){1'b0}}, shifted[7:0]}
                                    : {{(DMEM_MAX_W-8){shifted[7]}}, shifted[7:0]};
         SZ_HALF: res = is_unsigned ? {{(DMEM_MAX_W-16){1'b0}}, shifted[15:0]}
                                    : {{(DMEM_MAX_W-16){shifted[15]}}, shifted[15:0]};
         default: res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read
// port. Contents are deliberately not reset.
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = 10
) (
   input  logic                clk,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [AW-1:0]       waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic [AW-1:0]       raddr,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-lane writes and registered read; read data holds until the next read.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single outstanding byte/half/word load-store
// requests against a dmem_array, with range and size error reporting.
// Build option: DATA_MEM_ALIGN_CHECK_EN -- when defined, misaligned half/word
// accesses are rejected with resp_err; otherwise the offending low address
// bits are dropped and the access proceeds aligned.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | req_ready high, waiting for a request
// ST_RD_WAIT | load accepted; array read done, counting down the read latency
// ST_RESP    | resp_valid high for this one cycle
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int NB     = DATA_W / 8;
   localparam int LANE_W = $clog2(NB);
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = 3;

   state_e              state;
   logic [CNT_W-1:0]    cnt;
   size_e               size_q;
   logic                uns_q;
   logic [LANE_W-1:0]   off_q;

   size_e               req_sz;
   logic [LANE_W-1:0]   req_off;
   logic [LANE_W-1:0]   eff_off;
   logic [ADDR_W-1:0]   word_idx;
   logic                out_of_range;
   logic                misalign;
   logic                req_err;
   logic                accept;
   logic [NB-1:0]       be;
   logic [DATA_W-1:0]   wdata_rep;
   logic [DATA_W-1:0]   mem_rdata;

   assign req_sz       = size_e'(req_size);
   assign req_off      = req_addr[LANE_W-1:0];
   assign word_idx     = req_addr >> LANE_W;
   assign out_of_range = (word_idx >= ADDR_W'(DEPTH));
   assign accept       = req_valid & req_ready;

`ifdef DATA_MEM_ALIGN_CHECK_EN
   // Misaligned half/word accesses become errors; the offset is used as given.
   always_comb begin
      misalign = ((req_sz == SZ_HALF) && req_off[0]) ||
                 ((req_sz == SZ_WORD) && (req_off != '0));
      eff_off  = req_off;
   end
`else
   // Misaligned half/word accesses are silently aligned down.
   always_comb begin
      misalign = 1'b0;
      eff_off  = req_off;
      if (req_sz == SZ_HALF) eff_off = {req_off[LANE_W-1:1], 1'b0};
      if (req_sz == SZ_WORD) eff_off = '0;
   end
`endif

   assign req_err = out_of_range | misalign | (req_sz == SZ_RSVD);

   // Byte-lane enables and store data replicated across lanes.
   always_comb begin
      be        = '0;
      wdata_rep = req_wdata;
      case (req_sz)
         SZ_BYTE: begin
            be        = NB'(1) << eff_off;
            wdata_rep = {NB{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            be        = NB'(3) << eff_off;
            wdata_rep = {(NB/2){req_wdata[15:0]}};
         end
         SZ_WORD: be = '1;
         default: be = '0;
      endcase
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (MEM_AW)
   ) u_array (
      .clk   (clk),
      .we    (accept & req_we & ~req_err),
      .be    (be),
      .waddr (word_idx[MEM_AW-1:0]),
      .wdata (wdata_rep),
      .re    (accept & ~req_we & ~req_err),
      .raddr (word_idx[MEM_AW-1:0]),
      .rdata (mem_rdata)
   );

   // Request/response sequencing. Loads answer RD_LAT+1 edges after the
   // acceptance edge: the array read lands on the acceptance edge, then the
   // counter holds RD_WAIT for the remaining latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         size_q     <= SZ_BYTE;
         uns_q      <= 1'b0;
         off_q      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  size_q    <= req_sz;
                  uns_q     <= req_unsigned;
                  off_q     <= eff_off;
                  req_ready <= 1'b0;
                  if (req_we || req_err) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= req_err;
                     resp_rdata <= '0;
                  end else begin
                     state <= ST_RD_WAIT;
                     cnt   <= CNT_W'(RD_LAT);
                  end
               end
            end
            ST_RD_WAIT: begin
               if (cnt == '0) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= DATA_W'(lane_extract(DMEM_MAX_W'(mem_rdata),
                                                     6'(off_q), size_q, uns_q));
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_rdata <= '0;
               resp_err   <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the driver pushes the hand-computed
// response for each accepted request; the monitor pops and compares whenever
// resp_valid is seen.
module tb_data_mem_ctrl;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 32;
   localparam int RD_LAT = 3;
   // Negedge-to-negedge distance from the acceptance decision to the response:
   // stores/errors answer right after the acceptance edge, loads RD_LAT+1
   // edges after it.
   localparam int ST_LAT = 1;
   localparam int LD_LAT = RD_LAT + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   data_mem_ctrl #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every response is matched against the oldest expectation;
   // outside responses the data/error outputs must stay quiet.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_resp: got resp_valid rdata=%h err=%b expected no response",
                     resp_rdata, resp_err);
         end else begin
            mon_e = q.pop_front();
            chk({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
            chk({mon_e.name, "_err"}, 32'(resp_err), 32'(mon_e.err));
            chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
         end
      end else if (rst === 1'b0) begin
         chk("quiet_outputs", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'h0);
      end
   end

   // Present a request at a negedge and hold it until accepted; leaves
   // req_valid high so the caller can chain requests back to back.
   task automatic issue(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit push);
      int   waited = 0;
      exp_t e;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      while (req_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_accept_timeout: got req_ready=%b expected 1", name, req_ready);
         req_valid = 1'b0;
         return;
      end
      if (push) begin
         e.name  = name;
         e.rdata = exp_rdata;
         e.err   = exp_err;
         e.lat   = (we || exp_err) ? ST_LAT : LD_LAT;
         e.acc   = cyc;
         q.push_back(e);
      end
      @(negedge clk);
      chk({name, "_ready_low"}, 32'(req_ready), 32'h0);
   endtask

   // Drop the request, scramble the request fields, and wait for all
   // outstanding responses.
   task automatic drain();
      int n = 0;
      req_valid    = 1'b0;
      req_we       = 1'($urandom_range(0, 1));
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr     = $urandom;
      req_wdata    = $urandom;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic ld(input string name, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] exp_rdata, input logic exp_err);
      issue(name, 1'b0, size, uns, addr, 32'h0, exp_rdata, exp_err, 1'b1);
      drain();
   endtask

   task automatic st(input string name, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic exp_err);
      issue(name, 1'b1, size, 1'b0, addr, wdata, 32'h0, exp_err, 1'b1);
      drain();
   endtask

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h1);
      chk("rst_valid", 32'(resp_valid), 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      st("sw_4", 2'b10, 32'h4, 32'h1234_5678, 1'b0);
      ld("lb_5", 2'b00, 1'b0, 32'h5, 32'h0000_0056, 1'b0);
      st("sw_0", 2'b10, 32'h0, 32'hCAFE_F00D, 1'b0);
      st("sw_8", 2'b10, 32'h8, 32'hAABB_CCDD, 1'b0);
      st("sb_8", 2'b00, 32'h8, 32'h1234_5680, 1'b0);
      ld("lb_8", 2'b00, 1'b0, 32'h8, 32'hFFFF_FF80, 1'b0);
      ld("lbu_8", 2'b00, 1'b1, 32'h8, 32'h0000_0080, 1'b0);
      ld("lw_8", 2'b10, 1'b0, 32'h8, 32'hAABB_CC80, 1'b0);
      ld("lh_6", 2'b01, 1'b0, 32'h6, 32'h0000_1234, 1'b0);
      ld("lh_4", 2'b01, 1'b0, 32'h4, 32'h0000_5678, 1'b0);
      ld("lhu_a", 2'b01, 1'b1, 32'hA, 32'h0000_AABB, 1'b0);
      ld("lh_a", 2'b01, 1'b0, 32'hA, 32'hFFFF_AABB, 1'b0);
      st("sh_a", 2'b01, 32'hA, 32'h1234_BEEF, 1'b0);
      ld("lw_8b", 2'b10, 1'b0, 32'h8, 32'hBEEF_CC80, 1'b0);
      ld("lb_b", 2'b00, 1'b0, 32'hB, 32'hFFFF_FFBE, 1'b0);
      ld("lbu_9", 2'b00, 1'b1, 32'h9, 32'h0000_00CC, 1'b0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
      ld("lh_3", 2'b01, 1'b0, 32'h3, 32'h0, 1'b1);
      ld("lw_5", 2'b10, 1'b0, 32'h5, 32'h0, 1'b1);
`else
      ld("lh_3", 2'b01, 1'b0, 32'h3, 32'hFFFF_CAFE, 1'b0);
      ld("lw_5", 2'b10, 1'b0, 32'h5, 32'h1234_5678, 1'b0);
`endif
      ld("lw_oor", 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b1);
      st("sw_oor", 2'b10, 32'(4 * DEPTH), 32'hDEAD_BEEF, 1'b1);
      ld("lw_0", 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
      ld("rsvd", 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);

      // Three requests with req_valid held high throughout.
      issue("b2b_sw", 1'b1, 2'b10, 1'b0, 32'hC, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
      issue("b2b_lw", 1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'h1111_1111, 1'b0, 1'b1);
      issue("b2b_lbu", 1'b0, 2'b00, 1'b1, 32'hD, 32'h0, 32'h0000_0011, 1'b0, 1'b1);
      drain();

      // Load aborted by reset one cycle after acceptance: no response allowed.
      issue("abort_ld", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rst_ready", 32'(req_ready), 32'h1);
      chk("abort_rst_valid", 32'(resp_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      ld("post_rst_lw4", 2'b10, 1'b0, 32'h4, 32'h1234_5678, 1'b0);
      ld("post_rst_lw8", 2'b10, 1'b0, 32'h8, 32'hBEEF_CC80, 1'b0);

      chk("queue_empty", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
